// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU constants: the zero-register address and default
//               register-file geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int unsigned c_default_data_w = 32;
    localparam int unsigned c_default_addr_w = 5;

    // Architectural zero register; compare after casting to the local ADDR_W.
    localparam logic [c_default_addr_w-1:0] REG_ZERO = '0;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Busy-bit scoreboard with outstanding-write count and a sticky
//               double-issue error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W = c_default_addr_w
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    output logic [(2**ADDR_W)-1:0]   busy,
    output logic [ADDR_W:0]          pend_cnt,
    output logic                     sb_err
);

    localparam int                c_depth = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_zero  = ADDR_W'(REG_ZERO);

    logic [c_depth-1:0] r_busy_q;
    logic [c_depth-1:0] w_busy_d;
    logic [ADDR_W:0]    r_pend_cnt_q;
    logic [ADDR_W:0]    w_pend_cnt_d;
    logic               r_sb_err_q;
    logic               w_sb_err_d;

    logic w_set;
    logic w_clr;
    logic w_same;
    logic w_inc;
    logic w_dec;

    always_comb begin
        w_set  = sb_set && (sb_addr != c_zero);
        w_clr  = wr_en && (wr_addr != c_zero);
        w_same = w_set && w_clr && (sb_addr == wr_addr);

        // A set on the register being cleared re-arms it: the bit stays high
        // and the count is untouched.
        w_inc  = w_set && !r_busy_q[sb_addr];
        w_dec  = w_clr && r_busy_q[wr_addr] && !w_same;

        w_busy_d = r_busy_q;
        if (w_clr) begin
            w_busy_d[wr_addr] = 1'b0;
        end
        if (w_set) begin
            w_busy_d[sb_addr] = 1'b1;
        end

        w_pend_cnt_d = r_pend_cnt_q + (ADDR_W+1)'(w_inc) - (ADDR_W+1)'(w_dec);
        w_sb_err_d   = r_sb_err_q | (w_set && r_busy_q[sb_addr] && !w_same);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_q     <= '0;
            r_pend_cnt_q <= '0;
            r_sb_err_q   <= 1'b0;
        end else begin
            r_busy_q     <= w_busy_d;
            r_pend_cnt_q <= w_pend_cnt_d;
            r_sb_err_q   <= w_sb_err_d;
        end
    end

    assign busy     = r_busy_q;
    assign pend_cnt = r_pend_cnt_q;
    assign sb_err   = r_sb_err_q;

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Multi-port register file with write-to-read bypass, hardwired
//               r0 and a busy-bit scoreboard for issue hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W = c_default_data_w,
    parameter int ADDR_W = c_default_addr_w,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_busy,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    sb_set,
    input  logic [ADDR_W-1:0]       sb_addr,
    output logic [ADDR_W:0]         pend_cnt,
    output logic                    sb_err
);

    localparam int                c_depth     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_zero      = ADDR_W'(REG_ZERO);
    localparam logic              c_bypass_en = (BYPASS != 0);

    logic [DATA_W-1:0]  r_regs_q [c_depth];
    logic [DATA_W-1:0]  w_regs_d [c_depth];
    logic [c_depth-1:0] w_busy;
    logic               w_wr_ok;

    assign w_wr_ok = wr_en && (wr_addr != c_zero);

    always_comb begin
        w_regs_d = r_regs_q;
        if (w_wr_ok) begin
            w_regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_depth; i++) begin
                r_regs_q[i] <= '0;
            end
        end else begin
            r_regs_q <= w_regs_d;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .busy     (w_busy),
        .pend_cnt (pend_cnt),
        .sb_err   (sb_err)
    );

    // A forwarded write is by definition the one that retires the pending
    // producer, so a bypassed read also reports not-busy.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_hit;

        assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];
        assign w_hit  = c_bypass_en && w_wr_ok && (w_addr == wr_addr);

        assign rd_data[k*DATA_W +: DATA_W] = (w_addr == c_zero) ? '0      :
                                             w_hit              ? wr_data :
                                                                  r_regs_q[w_addr];
        assign rd_busy[k] = (w_addr != c_zero) && !w_hit && w_busy[w_addr];
    end

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Self-checking bench for regfile_sb, bypass and no-bypass
//               instances against a behavioural register/scoreboard model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    localparam int c_dw = 32;
    localparam int c_aw = 5;
    localparam int c_nr = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [c_nr*c_aw-1:0] rd_addr;
    logic                 wr_en;
    logic [c_aw-1:0]      wr_addr;
    logic [c_dw-1:0]      wr_data;
    logic                 sb_set;
    logic [c_aw-1:0]      sb_addr;

    logic [c_nr*c_dw-1:0] rd_data_b, rd_data_n;
    logic [c_nr-1:0]      rd_busy_b, rd_busy_n;
    logic [c_aw:0]        pend_b, pend_n;
    logic                 err_b, err_n;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    logic [c_dw-1:0] m_regs [32];
    bit              m_busy [32];
    bit              m_err;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(c_dw), .ADDR_W(c_aw), .NRD(c_nr), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set),
        .sb_addr(sb_addr), .pend_cnt(pend_b), .sb_err(err_b)
    );

    regfile_sb #(.DATA_W(c_dw), .ADDR_W(c_aw), .NRD(c_nr), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set),
        .sb_addr(sb_addr), .pend_cnt(pend_n), .sb_err(err_n)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: registers, busy set, error flag updated from the architectural rules.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] <= '0;
                m_busy[i] <= 1'b0;
            end
            m_err <= 1'b0;
        end else begin
            if (sb_set && sb_addr != 0 && m_busy[sb_addr] && !(wr_en && wr_addr == sb_addr))
                m_err <= 1'b1;
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] <= wr_data;
                m_busy[wr_addr] <= 1'b0;
            end
            if (sb_set && sb_addr != 0)
                m_busy[sb_addr] <= 1'b1;
        end
    end

    function automatic logic [c_dw-1:0] exp_data(input bit byp, input logic [c_aw-1:0] a);
        if (a == 0) return '0;
        if (byp && wr_en && wr_addr != 0 && a == wr_addr) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input bit byp, input logic [c_aw-1:0] a);
        if (a == 0) return 1'b0;
        if (byp && wr_en && wr_addr != 0 && a == wr_addr) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [c_aw:0] exp_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return (c_aw+1)'(n);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < c_nr; k++) begin
                check($sformatf("rd_data_byp[%0d]", k), 64'(rd_data_b[k*c_dw +: c_dw]),
                      64'(exp_data(1'b1, rd_addr[k*c_aw +: c_aw])));
                check($sformatf("rd_data_nob[%0d]", k), 64'(rd_data_n[k*c_dw +: c_dw]),
                      64'(exp_data(1'b0, rd_addr[k*c_aw +: c_aw])));
                check($sformatf("rd_busy_byp[%0d]", k), 64'(rd_busy_b[k]),
                      64'(exp_busy(1'b1, rd_addr[k*c_aw +: c_aw])));
                check($sformatf("rd_busy_nob[%0d]", k), 64'(rd_busy_n[k]),
                      64'(exp_busy(1'b0, rd_addr[k*c_aw +: c_aw])));
            end
            check("pend_cnt_byp", 64'(pend_b), 64'(exp_cnt()));
            check("pend_cnt_nob", 64'(pend_n), 64'(exp_cnt()));
            check("sb_err_byp", 64'(err_b), 64'(m_err));
            check("sb_err_nob", 64'(err_n), 64'(m_err));
        end
    end

    task automatic drive(input logic r, input logic [4:0] ra1, input logic [4:0] ra0,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ss, input logic [4:0] sa);
        rst = r; rd_addr = {ra1, ra0};
        wr_en = we; wr_addr = wa; wr_data = wd;
        sb_set = ss; sb_addr = sa;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_en = 1'b1;

        // Reset state
        drive(0, 5, 5, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("lit_reset_data", 64'(rd_data_b), 64'h0);
        check("lit_reset_busy", 64'(rd_busy_b), 64'h0);
        check("lit_reset_pend", 64'(pend_b), 64'h0);
        check("lit_reset_err", 64'(err_b), 64'h0);
        tick();

        // Write r5, read back; write to r0 ignored
        drive(0, 2, 1, 1, 5, 32'h0000_000A, 0, 0); tick();
        drive(0, 5, 5, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("lit_r5_byp", 64'(rd_data_b), {32'h0000_000A, 32'h0000_000A});
        check("lit_r5_nob", 64'(rd_data_n), {32'h0000_000A, 32'h0000_000A});
        tick();
        drive(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("lit_r0_zero", 64'(rd_data_b), 64'h0);
        tick();

        // Bypass versus stored value
        drive(0, 1, 1, 1, 6, 32'h3, 0, 0); tick();
        drive(0, 5, 6, 1, 6, 32'h5, 0, 0);
        @(negedge clk);
        check("lit_bypass_new", 64'(rd_data_b[31:0]), 64'h5);
        check("lit_nobypass_old", 64'(rd_data_n[31:0]), 64'h3);
        tick();
        drive(0, 6, 6, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("lit_nob_after_wr", 64'(rd_data_n[31:0]), 64'h5);
        tick();

        // Issue then retire r7
        drive(0, 7, 7, 0, 0, 0, 1, 7);
        @(negedge clk);
        check("lit_busy_issue_cycle", 64'(rd_busy_b), 64'h0);
        tick();
        drive(0, 7, 7, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("lit_busy_r7", 64'(rd_busy_b), 64'h3);
        check("lit_pend_1", 64'(pend_b), 64'h1);
        tick();
        drive(0, 7, 7, 1, 7, 32'h77, 0, 0);
        @(negedge clk);
        check("lit_busy_bypass_clr", 64'(rd_busy_b), 64'h0);
        check("lit_busy_nob_held", 64'(rd_busy_n), 64'h3);
        tick();
        drive(0, 7, 7, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("lit_r7_retired_busy", 64'(rd_busy_b), 64'h0);
        check("lit_r7_retired_pend", 64'(pend_b), 64'h0);
        check("lit_r7_data", 64'(rd_data_n), {32'h77, 32'h77});
        tick();

        // Set wins over simultaneous clear; double issue flags error
        drive(0, 0, 0, 0, 0, 0, 1, 7); tick();
        drive(0, 0, 0, 1, 7, 32'h88, 1, 7); tick();
        drive(0, 7, 7, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("lit_setclr_data", 64'(rd_data_b), {32'h88, 32'h88});
        check("lit_setclr_busy", 64'(rd_busy_n), 64'h3);
        check("lit_setclr_pend", 64'(pend_b), 64'h1);
        check("lit_setclr_err", 64'(err_b), 64'h0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 7); tick();
        drive(0, 7, 7, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("lit_dbl_err", 64'(err_b), 64'h1);
        check("lit_dbl_pend", 64'(pend_b), 64'h1);
        tick();

        // Set and clear on different registers: net count unchanged
        drive(0, 0, 0, 1, 7, 32'h99, 1, 9); tick();
        drive(0, 9, 7, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("lit_swap_pend", 64'(pend_n), 64'h1);
        check("lit_swap_busy", 64'(rd_busy_n), 64'h2);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 1, 9, 32'h1234_5678, 0, 0);
        @(negedge clk);
        check("lit_r0_set_pend", 64'(pend_b), 64'h1);
        tick();

        // Fill every register's busy bit to reach the maximum count
        for (int i = 1; i < 32; i++) begin
            drive(0, 5'(i), 5'(i - 1), 0, 0, 0, 1, 5'(i));
            tick();
        end
        drive(0, 31, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("lit_pend_max", 64'(pend_b), 64'd31);
        tick();
        for (int i = 1; i < 32; i++) begin
            drive(0, 5'(i), 5'(31 - i), 1, 5'(i), 32'(i) * 32'h0101_0101, 0, 0);
            tick();
        end
        drive(0, 30, 3, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("lit_pend_drained", 64'(pend_b), 64'd0);
        check("lit_r3_pattern", 64'(rd_data_b[31:0]), 64'h0303_0303);
        tick();

        // Reset in the middle of an issue sequence
        drive(0, 0, 0, 0, 0, 0, 1, 3); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 4); tick();
        drive(1, 0, 0, 1, 6, 32'hFF, 1, 5); tick();
        drive(0, 6, 5, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("lit_rst_pend", 64'(pend_b), 64'h0);
        check("lit_rst_busy", 64'(rd_busy_n), 64'h0);
        check("lit_rst_data", 64'(rd_data_n), 64'h0);
        check("lit_rst_err", 64'(err_n), 64'h0);
        tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_regfile_sb
`default_nettype wire
